// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider.
// The master modport is the side that supplies operands and consumes results.
interface seq_divider_if #(
    parameter int DW = 8,
    parameter int VW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          dz;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, dz
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, dz
    );
endinterface

// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider, one radix-2 step per clock.
// Results are held in dedicated registers so they stay stable outside DONE.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready=1
// BUSY  | shifting/subtracting, one quotient bit per cycle
// DONE  | result presented, out_valid=1, waiting for out_ready
module seq_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_divider_if.slave bus
);
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [VW-1:0] pr;
    logic [DW-1:0] q_sr;
    logic [VW-1:0] dvsr;
    logic [CW-1:0] cnt;
    logic [DW-1:0] quotient_r;
    logic [VW-1:0] remainder_r;
    logic          dz_r;

    logic [VW:0]   pr_shift;
    logic [VW-1:0] diff_lo;
    logic          fits;
    logic [VW-1:0] pr_next;
    logic [DW-1:0] q_next;

    // The stored remainder never exceeds VW bits; only the shifted value needs the extra bit.
    always_comb begin
        pr_shift = {pr, q_sr[DW-1]};
        fits     = (pr_shift >= {1'b0, dvsr});
        diff_lo  = pr_shift[VW-1:0] - dvsr;
        pr_next  = fits ? diff_lo : pr_shift[VW-1:0];
        q_next   = {q_sr[DW-2:0], fits};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pr          <= '0;
            q_sr        <= '0;
            dvsr        <= '0;
            cnt         <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
            dz_r        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        dvsr <= bus.divisor;
                        pr   <= '0;
                        q_sr <= bus.dividend;
                        cnt  <= '0;
                        if (bus.divisor == '0) begin
                            quotient_r  <= '1;
                            remainder_r <= bus.dividend[VW-1:0];
                            dz_r        <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            dz_r  <= 1'b0;
                            state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    pr   <= pr_next;
                    q_sr <= q_next;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(DW - 1)) begin
                        quotient_r  <= q_next;
                        remainder_r <= pr_next;
                        state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;
    assign bus.dz        = dz_r;
endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected results queued at operand acceptance,
// popped and compared when a result is transferred.
module tb_seq_divider;
    localparam int DW = 8;
    localparam int VW = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seq_divider_if #(.DW(DW), .VW(VW)) bus();

    seq_divider #(.DW(DW), .VW(VW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] a;
        logic [3:0] d;
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    function automatic exp_t model(input logic [7:0] a, input logic [3:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        if (d == 4'd0) begin
            e.q  = 8'hFF;
            e.r  = a[3:0];
            e.dz = 1'b1;
        end else begin
            e.q  = a / {4'd0, d};
            e.r  = 4'(a % {4'd0, d});
            e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (3) @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.quotient !== 8'd0) begin errors++; $display("FAIL reset_quotient: got %0d expected 0", bus.quotient); end
        checks++; if (bus.remainder !== 4'd0) begin errors++; $display("FAIL reset_remainder: got %0d expected 0", bus.remainder); end
        checks++; if (bus.dz !== 1'b0) begin errors++; $display("FAIL reset_dz: got %b expected 0", bus.dz); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Latency is counted in negedges after in_valid is presented: the accept edge
    // plus DW BUSY steps for a normal op, just the accept edge for divide-by-zero.
    task automatic test_directed();
        logic [7:0] av [8];
        logic [3:0] dv [8];
        exp_t e;
        int lat;
        int exp_lat;
        av = '{8'd200, 8'd255, 8'd0, 8'd5, 8'd255, 8'd13, 8'd195, 8'd100};
        dv = '{4'd7,   4'd15,  4'd9, 4'd9, 4'd1,   4'd0,  4'd13,  4'd3};
        sb.delete();
        for (int i = 0; i < 8; i++) begin
            bus.dividend  = av[i];
            bus.divisor   = dv[i];
            bus.in_valid  = 1'b1;
            bus.out_ready = 1'b1;
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL directed_in_ready[%0d]: got %b expected 1", i, bus.in_ready); end
            if (bus.in_ready === 1'b1) sb.push_back(model(av[i], dv[i]));
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.dividend = 8'($urandom);
            bus.divisor  = 4'($urandom);
            lat = 1;
            while (bus.out_valid !== 1'b1 && lat < 40) begin
                @(negedge clk);
                lat++;
            end
            exp_lat = (dv[i] == 4'd0) ? 1 : DW + 1;
            checks++; if (lat != exp_lat) begin errors++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, exp_lat); end
            if (bus.out_valid === 1'b1 && sb.size() > 0) begin
                e = sb.pop_front();
                checks++; if (bus.quotient !== e.q) begin errors++; $display("FAIL directed_q %0d/%0d: got %0d expected %0d", e.a, e.d, bus.quotient, e.q); end
                checks++; if (bus.remainder !== e.r) begin errors++; $display("FAIL directed_r %0d/%0d: got %0d expected %0d", e.a, e.d, bus.remainder, e.r); end
                checks++; if (bus.dz !== e.dz) begin errors++; $display("FAIL directed_dz %0d/%0d: got %b expected %b", e.a, e.d, bus.dz, e.dz); end
            end else begin
                checks++; errors++;
                $display("FAIL directed_output[%0d]: got no result expected one", i);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        int lat;
        sb.delete();
        bus.out_ready = 1'b0;
        bus.dividend  = 8'd100;
        bus.divisor   = 4'd3;
        bus.in_valid  = 1'b1;
        if (bus.in_ready === 1'b1) sb.push_back(model(8'd100, 4'd3));
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (bus.out_valid !== 1'b1 || sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL bp_output: got no result expected one");
            return;
        end
        e = sb.pop_front();
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.dividend = 8'($urandom);
            bus.divisor  = 4'($urandom_range(1, 15));
            @(negedge clk);
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", i, bus.out_valid); end
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, bus.in_ready); end
            checks++; if (bus.quotient !== e.q) begin errors++; $display("FAIL bp_q[%0d]: got %0d expected %0d", i, bus.quotient, e.q); end
            checks++; if (bus.remainder !== e.r) begin errors++; $display("FAIL bp_r[%0d]: got %0d expected %0d", i, bus.remainder, e.r); end
            checks++; if (bus.dz !== e.dz) begin errors++; $display("FAIL bp_dz[%0d]: got %b expected %b", i, bus.dz, e.dz); end
        end
        // Release with in_valid still high: DONE must not accept it.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.dividend  = 8'd50;
        bus.divisor   = 4'd5;
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b expected 1", bus.in_ready); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_single_transfer: got out_valid %b expected 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_no_accept: got in_ready %b expected 1", bus.in_ready); end
    endtask

    task automatic test_reset_mid_busy();
        exp_t e;
        int lat;
        sb.delete();
        bus.out_ready = 1'b1;
        bus.dividend  = 8'd200;
        bus.divisor   = 4'd7;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.quotient !== 8'd0) begin errors++; $display("FAIL midrst_q: got %0d expected 0", bus.quotient); end
        checks++; if (bus.remainder !== 4'd0) begin errors++; $display("FAIL midrst_r: got %0d expected 0", bus.remainder); end
        rst_n = 1'b1;
        @(negedge clk);
        bus.dividend = 8'd77;
        bus.divisor  = 4'd6;
        bus.in_valid = 1'b1;
        if (bus.in_ready === 1'b1) sb.push_back(model(8'd77, 4'd6));
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (bus.out_valid === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            checks++; if (bus.quotient !== e.q) begin errors++; $display("FAIL midrst_new_q: got %0d expected %0d", bus.quotient, e.q); end
            checks++; if (bus.remainder !== e.r) begin errors++; $display("FAIL midrst_new_r: got %0d expected %0d", bus.remainder, e.r); end
        end else begin
            checks++; errors++;
            $display("FAIL midrst_new_output: got no result expected one");
        end
        @(negedge clk);
    endtask

    task automatic test_exhaustive();
        exp_t e;
        int k;
        int cyc;
        logic [11:0] recon;
        sb.delete();
        k = 0;
        cyc = 0;
        while ((k < 4096 || sb.size() > 0) && cyc < 70000) begin
            bus.in_valid  = (k < 4096) && ($urandom_range(0, 3) != 0);
            bus.dividend  = 8'(k >> 4);
            bus.divisor   = 4'(k);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
                sb.push_back(model(8'(k >> 4), 4'(k)));
                k++;
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL exh_unexpected: got result q=%0d expected none", bus.quotient);
                end else begin
                    e = sb.pop_front();
                    checks++; if (bus.quotient !== e.q) begin errors++; $display("FAIL exh_q %0d/%0d: got %0d expected %0d", e.a, e.d, bus.quotient, e.q); end
                    checks++; if (bus.remainder !== e.r) begin errors++; $display("FAIL exh_r %0d/%0d: got %0d expected %0d", e.a, e.d, bus.remainder, e.r); end
                    checks++; if (bus.dz !== e.dz) begin errors++; $display("FAIL exh_dz %0d/%0d: got %b expected %b", e.a, e.d, bus.dz, e.dz); end
                    if (e.d != 4'd0) begin
                        recon = 12'(bus.quotient) * 12'(e.d) + 12'(bus.remainder);
                        checks++; if (recon !== 12'(e.a)) begin errors++; $display("FAIL exh_identity %0d/%0d: got %0d expected %0d", e.a, e.d, recon, e.a); end
                        checks++; if (!(bus.remainder < e.d)) begin errors++; $display("FAIL exh_r_lt_d %0d/%0d: got %0d expected <%0d", e.a, e.d, bus.remainder, e.d); end
                        if ((e.a % {4'd0, e.d}) == 8'd0 && (e.a / {4'd0, e.d}) < 8'd16) begin
                            checks++; if (bus.remainder !== 4'd0) begin errors++; $display("FAIL exh_round_trip %0d/%0d: got r=%0d expected 0", e.a, e.d, bus.remainder); end
                        end
                    end
                end
            end
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 70000) begin
            checks++; errors++;
            $display("FAIL exh_timeout: got %0d ops issued expected 4096 and drained", k);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_busy();
        test_exhaustive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
